// File: rtl/drum_step_sequencer_pkg.sv
// Shared types and defaults for the drum step sequencer: FSM state encoding,
// default geometry and an index-width helper.
package drum_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_LANES     = 4;
  localparam int DEF_STEPS     = 8;
  localparam int DEF_DIV_W     = 16;
  localparam int DEF_PULSE_LEN = 4;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_LANE_W = idx_w(DEF_LANES);
  localparam int DEF_STEP_W = idx_w(DEF_STEPS);

endpackage

// File: rtl/drum_step_sequencer_if.sv
// Pattern-load handshake between the host decoder (master) and the sequencer (slave).
interface drum_seq_if
  import drum_seq_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int STEPS = DEF_STEPS
);
  localparam int LANE_W = idx_w(LANES);

  logic              load_valid;
  logic              load_ready;
  logic [LANE_W-1:0] load_lane;
  logic [STEPS-1:0]  load_pattern;

  modport master (output load_valid, output load_lane, output load_pattern, input load_ready);
  modport slave  (input load_valid, input load_lane, input load_pattern, output load_ready);
endinterface

// File: rtl/drum_step_sequencer_pulse_gen.sv
// Per-lane trigger stretcher: a hit loads the counter with the pulse length and
// the trigger stays high while the counter is non-zero.
module drum_pulse_gen #(
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hit,
  input  logic [LEN_W-1:0] len,
  output logic             trig
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  // Next counter value: clear wins over a new hit, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = len;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LEN_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign trig = (cnt_q != '0);

endmodule

// File: rtl/drum_step_sequencer.sv
// Multi-lane drum step sequencer: tempo divider, shared step pointer, per-lane
// circular patterns and a single pending load slot committed at bar boundaries.
module drum_step_sequencer
  import drum_seq_pkg::*;
#(
  parameter  int LANES     = DEF_LANES,
  parameter  int STEPS     = DEF_STEPS,
  parameter  int DIV_W     = DEF_DIV_W,
  parameter  int PULSE_LEN = DEF_PULSE_LEN,
  localparam int LANE_W    = idx_w(LANES),
  localparam int STEP_W    = idx_w(STEPS),
  localparam int LEN_W     = idx_w(PULSE_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DIV_W-1:0]  tempo_div,
  drum_seq_if.slave         load_if,
  output logic              step_tick,
  output logic [STEP_W-1:0] step_idx,
  output logic [LANES-1:0]  trig,
  output logic              busy
);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [STEP_W-1:0]  next_step_q, next_step_d;
  logic [STEP_W-1:0]  step_idx_q, step_idx_d;
  logic               step_tick_q, step_tick_d;
  logic               busy_q, busy_d;
  logic [STEPS-1:0]   pat_q [LANES];
  logic [STEPS-1:0]   pat_d [LANES];
  logic               pend_q, pend_d;
  logic [LANE_W-1:0]  pend_lane_q, pend_lane_d;
  logic [STEPS-1:0]   pend_pat_q, pend_pat_d;

  logic [DIV_W-1:0]   div_eff_s;
  logic [LEN_W-1:0]   plen_s;
  logic               tick_s;
  logic               stop_s;
  logic               last_step_s;
  logic               commit_s;
  logic               accept_s;
  logic [LANES-1:0]   hit_s;

  // A zero divider would leave no low clock between hits, so it plays as 1;
  // the pulse is clipped to one clock shorter than the step period.
  assign div_eff_s   = (tempo_div == '0) ? DIV_W'(1) : tempo_div;
  assign plen_s      = (div_eff_s >= DIV_W'(PULSE_LEN)) ? LEN_W'(PULSE_LEN) : div_eff_s[LEN_W-1:0];
  assign tick_s      = (state_q == RUN) && run && (div_cnt_q == '0);
  assign stop_s      = (state_q == RUN) && !run;
  assign last_step_s = (next_step_q == STEP_W'(STEPS - 1));
  assign commit_s    = pend_q && ((state_q == IDLE) || (tick_s && last_step_s));
  assign accept_s    = load_if.load_valid && !pend_q;

  // Lane hit strobes for the step about to be played.
  always_comb begin
    hit_s = '0;
    for (int l = 0; l < LANES; l++) begin
      hit_s[l] = tick_s && pat_q[l][next_step_q];
    end
  end

  // FSM, tempo divider and step pointer.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    next_step_d = next_step_q;
    step_idx_d  = step_idx_q;
    step_tick_d = 1'b0;
    case (state_q)
      IDLE: begin
        div_cnt_d   = '0;
        next_step_d = '0;
        step_idx_d  = '0;
        if (run) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!run) begin
          state_d     = IDLE;
          div_cnt_d   = '0;
          next_step_d = '0;
          step_idx_d  = '0;
        end else if (div_cnt_q == '0) begin
          step_tick_d = 1'b1;
          step_idx_d  = next_step_q;
          next_step_d = last_step_s ? '0 : next_step_q + STEP_W'(1);
          div_cnt_d   = div_eff_s;
        end else begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // Pending slot: commit has priority, and load_ready is low on a commit edge anyway.
  always_comb begin
    pat_d       = pat_q;
    pend_d      = pend_q;
    pend_lane_d = pend_lane_q;
    pend_pat_d  = pend_pat_q;
    if (commit_s) begin
      pend_d = 1'b0;
      if (32'(pend_lane_q) < LANES) begin
        pat_d[pend_lane_q] = pend_pat_q;
      end else begin
        pat_d = pat_q;
      end
    end else if (accept_s) begin
      pend_d      = 1'b1;
      pend_lane_d = load_if.load_lane;
      pend_pat_d  = load_if.load_pattern;
    end else begin
      pend_d = pend_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      next_step_q <= '0;
      step_idx_q  <= '0;
      step_tick_q <= 1'b0;
      busy_q      <= 1'b0;
      pat_q       <= '{default: '0};
      pend_q      <= 1'b0;
      pend_lane_q <= '0;
      pend_pat_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      next_step_q <= next_step_d;
      step_idx_q  <= step_idx_d;
      step_tick_q <= step_tick_d;
      busy_q      <= busy_d;
      pat_q       <= pat_d;
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
      pend_pat_q  <= pend_pat_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    drum_pulse_gen #(.LEN_W(LEN_W)) u_pulse (
      .clk  (clk),
      .rst  (rst),
      .clr  (stop_s),
      .hit  (hit_s[g]),
      .len  (plen_s),
      .trig (trig[g])
    );
  end

  assign load_if.load_ready = !pend_q;
  assign step_tick          = step_tick_q;
  assign step_idx           = step_idx_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed scoreboard bench for drum_step_sequencer: a pattern model pushes one
// record per expected step and the checker compares every clock of each step.
module tb_drum_step_sequencer;

  localparam int LANES     = 4;
  localparam int STEPS     = 8;
  localparam int DIV_W     = 16;
  localparam int PULSE_LEN = 4;
  localparam int LANE_W    = $clog2(LANES);
  localparam int STEP_W    = $clog2(STEPS);

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [DIV_W-1:0]  tempo_div;
  logic              step_tick;
  logic [STEP_W-1:0] step_idx;
  logic [LANES-1:0]  trig;
  logic              busy;

  drum_seq_if #(.LANES(LANES), .STEPS(STEPS)) lif ();

  drum_step_sequencer #(
    .LANES(LANES), .STEPS(STEPS), .DIV_W(DIV_W), .PULSE_LEN(PULSE_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .tempo_div (tempo_div),
    .load_if   (lif),
    .step_tick (step_tick),
    .step_idx  (step_idx),
    .trig      (trig),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               step;
    logic [LANES-1:0] mask;
    int               period;
    int               len;
    logic             ready;
  } rec_t;

  rec_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  logic [STEPS-1:0] m_pat [LANES];
  logic             m_pend;
  int               m_pend_lane;
  logic [STEPS-1:0] m_pend_pat;
  int               m_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    lif.load_valid = 1'b0;
  endtask

  task automatic push_steps(input int n, input int tdiv);
    rec_t r;
    int   d;
    d = (tdiv < 1) ? 1 : tdiv;
    for (int k = 0; k < n; k++) begin
      r.step   = m_step;
      r.period = d + 1;
      r.len    = (PULSE_LEN < d) ? PULSE_LEN : d;
      for (int l = 0; l < LANES; l++) r.mask[l] = m_pat[l][m_step];
      if (m_step == STEPS - 1 && m_pend) begin
        m_pat[m_pend_lane] = m_pend_pat;
        m_pend             = 1'b0;
      end
      r.ready = !m_pend;
      sb.push_back(r);
      m_step = (m_step + 1) % STEPS;
    end
  endtask

  task automatic play();
    rec_t        r;
    int          w;
    logic [31:0] e;
    w = 0;
    while (step_tick !== 1'b1 && w < 64) begin
      next_cycle();
      w++;
    end
    chk("tick_wait", 32'(step_tick), 32'd1);
    if (step_tick !== 1'b1) begin
      sb.delete();
      return;
    end
    while (sb.size() > 0) begin
      r = sb.pop_front();
      chk("step_idx", 32'(step_idx), 32'(r.step));
      chk("busy_run", 32'(busy), 32'd1);
      chk("load_ready", 32'(lif.load_ready), 32'(r.ready));
      for (int c = 0; c < r.period; c++) begin
        if (c > 0) chk("tick_low", 32'(step_tick), 32'd0);
        e = '0;
        if (c < r.len) e[LANES-1:0] = r.mask;
        chk("trig", 32'(trig), e);
        next_cycle();
      end
      chk("tick_period", 32'(step_tick), 32'd1);
    end
  endtask

  task automatic do_load(input int lane, input logic [STEPS-1:0] pat, input bit idle);
    lif.load_valid   = 1'b1;
    lif.load_lane    = LANE_W'(lane);
    lif.load_pattern = pat;
    if (idle) begin
      next_cycle();
      chk("ready_after_accept", 32'(lif.load_ready), 32'd0);
      next_cycle();
      chk("ready_after_commit", 32'(lif.load_ready), 32'd1);
      m_pat[lane] = pat;
    end else begin
      m_pend      = 1'b1;
      m_pend_lane = lane;
      m_pend_pat  = pat;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_step_tick", 32'(step_tick), 32'd0);
    chk("rst_step_idx", 32'(step_idx), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_ready", 32'(lif.load_ready), 32'd1);
  endtask

  task automatic start_run();
    run = 1'b1;
    next_cycle();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_no_tick", 32'(step_tick), 32'd0);
    next_cycle();
    chk("first_tick", 32'(step_tick), 32'd1);
    chk("first_step", 32'(step_idx), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    run              = 1'b0;
    tempo_div        = 16'd9;
    lif.load_valid   = 1'b0;
    lif.load_lane    = '0;
    lif.load_pattern = '0;
    for (int l = 0; l < LANES; l++) m_pat[l] = '0;
    m_pend = 1'b0; m_pend_lane = 0; m_pend_pat = '0; m_step = 0;

    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    next_cycle();

    // IDLE loads commit immediately.
    do_load(0, 8'h0B, 1'b1);
    do_load(1, 8'h0F, 1'b1);

    // Two bars at P=10.
    tempo_div = 16'd9;
    start_run();
    push_steps(16, 9);
    play();

    // Step 0 already latched P=10; P=3 from step 1 on.
    push_steps(1, 9);
    tempo_div = 16'd2;
    push_steps(15, 2);
    play();

    // Load lane0 while step 3 plays; it lands at the next bar.
    push_steps(3, 2);
    play();
    push_steps(1, 2);
    do_load(0, 8'h80, 1'b0);
    push_steps(12, 2);
    play();

    // Divider 0 behaves as 1; lane2 all ones.
    push_steps(1, 2);
    tempo_div = 16'd0;
    do_load(2, 8'hFF, 1'b0);
    push_steps(15, 0);
    play();

    // Stop while step 5 plays, then restart from step 0.
    push_steps(5, 0);
    play();
    chk("pre_stop_step", 32'(step_idx), 32'd5);
    run = 1'b0;
    next_cycle();
    chk("stop_trig", 32'(trig), 32'd0);
    chk("stop_tick", 32'(step_tick), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_step_idx", 32'(step_idx), 32'd0);
    m_step    = 0;
    tempo_div = 16'd9;
    start_run();
    push_steps(8, 9);
    play();

    // Reset mid-run with a load pending.
    lif.load_valid   = 1'b1;
    lif.load_lane    = LANE_W'(3);
    lif.load_pattern = 8'h55;
    next_cycle();
    chk("pend_before_rst", 32'(lif.load_ready), 32'd0);
    rst = 1'b1;
    next_cycle();
    chk_reset_vals();
    rst = 1'b0;
    for (int l = 0; l < LANES; l++) m_pat[l] = '0;
    m_pend = 1'b0; m_step = 0;
    push_steps(8, 9);
    play();

    run = 1'b0;
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
